// File: rtl/digi_readout_seq.sv
// digi_readout_seq: scans enabled ADC channels after an end-of-sample trigger and emits channel-tagged words
// Ports: CK50 clock, RST_n sync active-low reset, EOS trigger, CHAN_EN channel mask,
//   SAMPLE_NUM words per channel, DIN packed FWFT channel data, RD_REQUEST per-channel pop,
//   DOUT/DVALID/DREADY output handshake, ZYNQ_RD_EN sequence active, SEQ_DONE end pulse.
// Optional macro DIGI_SEQ_HEADER_EN adds a {4'hA, EVCNT} header word at the start of each sequence.
module digi_readout_seq #(
  parameter int CHAN = 8,
  parameter int ADC_WIDTH = 12,
  parameter int WIDTH = 16,
  parameter int ORDER = 0
) (
  input  logic                      CK50,
  input  logic                      RST_n,
  input  logic                      EOS,
  input  logic [CHAN-1:0]           CHAN_EN,
  input  logic [11:0]               SAMPLE_NUM,
  input  logic [CHAN*ADC_WIDTH-1:0] DIN,
  output logic [CHAN-1:0]           RD_REQUEST,
  output logic [WIDTH-1:0]          DOUT,
  output logic                      DVALID,
  input  logic                      DREADY,
  output logic                      ZYNQ_RD_EN,
  output logic                      SEQ_DONE
);
  localparam int SW = $clog2(CHAN);
  localparam int TW = WIDTH - ADC_WIDTH;
  localparam int EW = WIDTH - 4;
  typedef enum logic [2:0] {IDLE, SELECT, DATA, DONE `ifdef DIGI_SEQ_HEADER_EN , HEADER `endif} state_t;
  state_t state, state_nx;
  logic [CHAN-1:0] pending, pending_nx;
  logic [11:0] nlat, nlat_nx, cnt, cnt_nx;
  logic [EW-1:0] evcnt, evcnt_nx;
  logic [SW-1:0] sel, sel_nx, pick;
  logic armed, armed_nx;
  always_ff @(posedge CK50) begin
    if (!RST_n) begin
      state <= IDLE;
      pending <= '0;
      nlat <= '0;
      cnt <= '0;
      evcnt <= '0;
      sel <= '0;
      armed <= 1'b0;
    end else begin
      state <= state_nx;
      pending <= pending_nx;
      nlat <= nlat_nx;
      cnt <= cnt_nx;
      evcnt <= evcnt_nx;
      sel <= sel_nx;
      armed <= armed_nx;
    end
  end
  // Scan in the opposite direction of priority so the last hit is the winner.
  always_comb begin
    pick = '0;
    for (int i = 0; i < CHAN; i++)
      if (pending[ORDER != 0 ? i : CHAN-1-i]) pick = SW'(ORDER != 0 ? i : CHAN-1-i);
  end
  always_comb begin
    state_nx = state;
    pending_nx = pending;
    nlat_nx = nlat;
    cnt_nx = cnt;
    evcnt_nx = evcnt;
    sel_nx = sel;
    armed_nx = armed;
    case (state)
      IDLE: begin
        armed_nx = armed | ~EOS;
        if (EOS && armed) begin
          pending_nx = CHAN_EN;
          nlat_nx = SAMPLE_NUM;
          armed_nx = 1'b0;
`ifdef DIGI_SEQ_HEADER_EN
          state_nx = HEADER;
`else
          state_nx = SELECT;
`endif
        end
      end
`ifdef DIGI_SEQ_HEADER_EN
      HEADER: state_nx = DREADY ? SELECT : HEADER;
`endif
      SELECT: begin
        sel_nx = pick;
        cnt_nx = '0;
        state_nx = (pending == '0 || nlat == '0) ? DONE : DATA;
      end
      DATA: if (DREADY) begin
        cnt_nx = cnt + 12'd1;
        if (cnt == nlat - 12'd1) begin
          pending_nx[sel] = 1'b0;
          state_nx = SELECT;
        end
      end
      DONE: begin
        evcnt_nx = evcnt + 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
`ifdef DIGI_SEQ_HEADER_EN
  assign DVALID = state == DATA || state == HEADER;
  assign DOUT = state == DATA ? {DIN[int'(sel)*ADC_WIDTH +: ADC_WIDTH], TW'(sel)} :
                state == HEADER ? {4'hA, evcnt} : '0;
`else
  assign DVALID = state == DATA;
  assign DOUT = state == DATA ? {DIN[int'(sel)*ADC_WIDTH +: ADC_WIDTH], TW'(sel)} : '0;
`endif
  assign RD_REQUEST = (state == DATA && DREADY) ? CHAN'(1) << sel : '0;
  assign ZYNQ_RD_EN = state != IDLE;
  assign SEQ_DONE = state == DONE;
endmodule

// File: tb/tb_digi_readout_seq.sv
// tb_digi_readout_seq: scoreboard bench running ascending and descending scan instances side by side
module tb_digi_readout_seq;
  localparam int CHAN = 8;
  localparam int AW = 12;
  localparam int W = 16;
  typedef struct {logic [W-1:0] w; int ch;} exp_t;
  logic clk = 1'b0;
  logic rst_n, eos, dready;
  logic [CHAN-1:0] chan_en;
  logic [11:0] sample_num;
  logic [CHAN*AW-1:0] din [2];
  logic [CHAN-1:0] rd [2];
  logic [W-1:0] dout [2];
  logic dvalid [2];
  logic zen [2];
  logic sdone [2];
  int pops [2][CHAN];
  int expc [2][CHAN];
  exp_t q [2][$];
  int checks = 0, errors = 0;
  int dn [2];
  int xfer [2];
  int exp_done = 0;
  int evm = 0;
  int mode = 0;
  int pat = 0;
  logic [3:0] patv = 4'b1001;
  logic [W-1:0] held [2];
  logic held_v [2];
  logic sdone_prev [2];
  always #5 clk = ~clk;
  digi_readout_seq #(.CHAN(CHAN), .ADC_WIDTH(AW), .WIDTH(W), .ORDER(0)) u_asc (
    .CK50(clk), .RST_n(rst_n), .EOS(eos), .CHAN_EN(chan_en), .SAMPLE_NUM(sample_num),
    .DIN(din[0]), .RD_REQUEST(rd[0]), .DOUT(dout[0]), .DVALID(dvalid[0]), .DREADY(dready),
    .ZYNQ_RD_EN(zen[0]), .SEQ_DONE(sdone[0]));
  digi_readout_seq #(.CHAN(CHAN), .ADC_WIDTH(AW), .WIDTH(W), .ORDER(1)) u_desc (
    .CK50(clk), .RST_n(rst_n), .EOS(eos), .CHAN_EN(chan_en), .SAMPLE_NUM(sample_num),
    .DIN(din[1]), .RD_REQUEST(rd[1]), .DOUT(dout[1]), .DVALID(dvalid[1]), .DREADY(dready),
    .ZYNQ_RD_EN(zen[1]), .SEQ_DONE(sdone[1]));
  function automatic logic [AW-1:0] word(input int c, input int n);
    return AW'(c * 331 + n * 97 + 5);
  endfunction
  // Each channel behaves as a FWFT FIFO whose head depends on how often it was popped.
  always_comb
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < CHAN; c++)
        din[k][c*AW +: AW] = word(c, pops[k][c]);
  always @(posedge clk)
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < CHAN; c++)
        if (rd[k][c]) pops[k][c] <= pops[k][c] + 1;
  always @(posedge clk) begin
    #2;
    dready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : mode == 2 ? patv[pat % 4] : 1'b0;
    pat++;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    logic [CHAN-1:0] er;
    for (int k = 0; k < 2; k++) begin
      if (dvalid[k] && held_v[k]) chk("dout hold", 32'(dout[k]), 32'(held[k]));
      held_v[k] = dvalid[k] && !dready;
      held[k] = dout[k];
      if (dvalid[k] && dready) begin
        xfer[k]++;
        chk("word expected", 32'(q[k].size() > 0), 1);
        if (q[k].size() > 0) begin
          e = q[k].pop_front();
          er = e.ch < 0 ? '0 : CHAN'(1) << e.ch;
          chk(k == 0 ? "dout asc" : "dout desc", 32'(dout[k]), 32'(e.w));
          chk("rd_request", 32'(rd[k]), 32'(er));
        end
        chk("zynq_rd_en active", 32'(zen[k]), 1);
      end else chk("rd_request idle", 32'(rd[k]), 0);
      if (sdone[k]) begin
        dn[k]++;
        chk("words left at done", q[k].size(), 0);
      end
      if (sdone_prev[k]) chk("zynq_rd_en after done", 32'(zen[k]), 0);
      sdone_prev[k] = sdone[k];
    end
  end
  task automatic push_expect(input logic [CHAN-1:0] m, input logic [11:0] n);
    for (int k = 0; k < 2; k++) begin
`ifdef DIGI_SEQ_HEADER_EN
      q[k].push_back('{{4'hA, 12'(evm)}, -1});
`endif
      for (int i = 0; i < CHAN; i++) begin
        int c = k == 0 ? i : CHAN - 1 - i;
        if (m[c])
          for (int j = 0; j < int'(n); j++) begin
            q[k].push_back('{{word(c, expc[k][c]), 4'(c)}, c});
            expc[k][c]++;
          end
      end
    end
    evm = (evm + 1) % 4096;
  endtask
  task automatic start(input logic [CHAN-1:0] m, input logic [11:0] n, input int rmode);
    chan_en = m;
    sample_num = n;
    mode = rmode;
    eos = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    push_expect(m, n);
    eos = 1'b1;
  endtask
  task automatic run_seq(input logic [CHAN-1:0] m, input logic [11:0] n, input int hold, input int rmode);
    int t = 0;
    start(m, n, rmode);
    exp_done++;
    repeat (hold) begin @(posedge clk); #1; end
    eos = 1'b0;
    while ((dn[0] < exp_done || dn[1] < exp_done) && t < 3000) begin @(posedge clk); t++; end
    chk("seq_done timeout", 32'(t < 3000), 1);
    @(posedge clk); #1;
  endtask
  task automatic check_zero(input string nm);
    for (int k = 0; k < 2; k++) begin
      chk({nm, " dvalid"}, 32'(dvalid[k]), 0);
      chk({nm, " rd_request"}, 32'(rd[k]), 0);
      chk({nm, " dout"}, 32'(dout[k]), 0);
      chk({nm, " zynq_rd_en"}, 32'(zen[k]), 0);
      chk({nm, " seq_done"}, 32'(sdone[k]), 0);
    end
  endtask
  initial begin
    exp_t e;
    int tgt, t;
    rst_n = 1'b0;
    eos = 1'b0;
    chan_en = '0;
    sample_num = '0;
    for (int k = 0; k < 2; k++) begin held_v[k] = 1'b0; sdone_prev[k] = 1'b0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_seq(8'h05, 12'd3, 1, 0);
    run_seq(8'h05, 12'd3, 1, 2);
    run_seq(8'h01, 12'd2, 100, 0);
    run_seq(8'h01, 12'd2, 1, 1);
    run_seq(8'h00, 12'd2, 1, 0);
    run_seq(8'hFF, 12'd1, 1, 1);
    run_seq(8'h81, 12'd0, 2, 0);
    for (int r = 0; r < 10; r++)
      run_seq(CHAN'($urandom_range(0, 255)), 12'($urandom_range(0, 4)), $urandom_range(1, 5), $urandom_range(0, 2));
    tgt = xfer[0] + 2;
    start(8'h01, 12'd5, 0);
    t = 0;
    while (xfer[0] < tgt && t < 200) begin @(posedge clk); t++; end
    chk("reset wait timeout", 32'(t < 200), 1);
    #1;
    rst_n = 1'b0;
    eos = 1'b0;
    mode = 3;
    @(posedge clk);
    @(negedge clk);
    check_zero("abort");
    for (int k = 0; k < 2; k++)
      while (q[k].size() > 0) begin
        e = q[k].pop_front();
        if (e.ch >= 0) expc[k][e.ch]--;
      end
    evm = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_seq(8'h00, 12'd3, 1, 0);
    repeat (5) @(posedge clk);
    chk("seq_done count asc", dn[0], exp_done);
    chk("seq_done count desc", dn[1], exp_done);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
